interconnect_config_loader: RTL
===============================

# interconnect_config_loader

Serial configuration loader sitting directly upstream of the per-LUT-input interconnect multiplexers. It accepts a bit-serial configuration stream with a valid/ready handshake and assembles `NUM_SEL` 5-bit selector codes. It range-checks each code, then commits all codes atomically to the parallel `interconnect_switch` bus. It also drives `prgm_b` / `CLB_prgm_b`, which gate when the muxes are allowed to route.

## Interface
Parameters:
- `NUM_SEL`, default 4: number of 5-bit selectors loaded per frame (one per LUT input).
- `SEL_W`, default 5: selector width; fixed at 5, because the mux decodes `5'b00000`–`5'b10111`.

Ports:
- `clk`  in  1  sole clock; all logic is on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle request to begin loading a frame.
- `cfg_bit`  in  1  serial configuration data.
- `cfg_valid`  in  1  `cfg_bit` is valid this cycle.
- `cfg_ready`  out  1  loader accepts `cfg_bit` this cycle.
- `interconnect_switch_bus`  out  `NUM_SEL*SEL_W`  committed selectors; selector i occupies `[i*5+4:i*5]`.
- `prgm_b`  out  1  1 = fabric programmed, muxes may route.
- `CLB_prgm_b`  out  1  0 = CLB programmed; the muxes route only when `prgm_b`=1 and `CLB_prgm_b`=0.
- `cfg_done`  out  1  one-cycle pulse when a frame commits.
- `cfg_err`  out  1  sticky error flag for a rejected frame.

## Operation
- States:
  - IDLE (after reset).
  - SHIFT: receiving data bits.
  - PAR: receiving the parity bit; only exists with the macro.
  - CHECK: one-cycle validation.
  - DONE: programmed.
  - ERROR: frame rejected.
- Reset values:
  - `interconnect_switch_bus` is all ones (every selector reads `5'b11111`, "unused").
  - `prgm_b`=0, `CLB_prgm_b`=1.
  - `cfg_ready`=0, `cfg_done`=0, `cfg_err`=0.
  - State is IDLE; bit and selector counters are 0.
- IDLE/DONE/ERROR with `start`=1 → SHIFT.
  - Clears `cfg_err`.
  - Drives `prgm_b`=0 and `CLB_prgm_b`=1 on the next cycle.
  - The committed bus holds its old value until the next commit.
- `start` is ignored in SHIFT, PAR and CHECK.
- SHIFT:
  - `cfg_ready`=1.
  - A bit is accepted only when `cfg_valid`&&`cfg_ready`; gaps in `cfg_valid` stall without limit.
  - Selectors are sent in order 0 first, each MSB first, into a 5-bit shift register.
  - After the 5th bit of a selector, the code is written to a shadow register, not to the output bus.
  - After the 5th bit of selector `NUM_SEL-1` → CHECK (or PAR with the macro).
- CHECK:
  - Each shadow code must be ≤ `5'b10111` or equal to `5'b11111`.
  - Codes `5'b11000`–`5'b11110` are reserved and make the frame invalid.
  - Valid frame → DONE: shadow copied to `interconnect_switch_bus`, `cfg_done` pulses for 1 cycle, `prgm_b`=1, `CLB_prgm_b`=0.
  - Invalid frame → ERROR: `cfg_err`=1, bus unchanged, `prgm_b`=0, `CLB_prgm_b`=1.
- `cfg_ready`=0 in every state except SHIFT and PAR.
- `rst` during any state aborts the load and restores all reset values, including the bus.

## Timing
- `cfg_ready` rises the cycle after `start` is sampled.
- Without the macro, a frame needs exactly `NUM_SEL*5` accepted bits.
  - Last bit accepted at edge N → CHECK during cycle N+1 → `cfg_done`, `prgm_b`, `CLB_prgm_b` and the bus all update at edge N+2.
  - With no stalls and `NUM_SEL`=4, that is 22 cycles from `start` to `prgm_b`=1.
- Bus, `prgm_b` and `CLB_prgm_b` change on the same edge, so downstream muxes never see a partial frame.
- `cfg_err` rises at the same edge an error frame would have committed; it is held until `start` or `rst`.

## Configuration
- Macro `CFG_PARITY_EN` defined:
  - Each selector is followed by one even-parity bit over its 5 bits; the frame is `NUM_SEL*6` bits.
  - The PAR state receives that bit.
  - Any parity mismatch is recorded and forces CHECK → ERROR, even if all codes are in range.
- Macro not defined: no parity bits, the PAR state is absent, and the frame is `NUM_SEL*5` bits.

## Test plan
- Basic load, `NUM_SEL`=4: `start`, then stream selectors 0–3 = `00011`, `10000`, `01111`, `11111`, no stalls → bus=`20'hFBE03`, `cfg_done` pulse, `prgm_b`=1 and `CLB_prgm_b`=0 at cycle 22.
- Stalled stream: same frame with `cfg_valid` low on alternate cycles → identical bus value; `prgm_b` stays 0 until the final bit plus 2 cycles.
- Reserved code: selector 1 = `11000` after a prior good load of `20'hFBE03` → `cfg_err`=1, bus stays `20'hFBE03`, `prgm_b`=0, `CLB_prgm_b`=1; a following valid frame clears `cfg_err`.
- Reset mid-load: `rst` asserted after 9 bits → bus=`20'hFFFFF`, `prgm_b`=0, `cfg_ready`=0; next `start` loads a full fresh frame correctly.
- `start` ignored: pulse `start` during SHIFT at bit 7 → bit counter is not reset and the frame completes normally.
- With `CFG_PARITY_EN`: valid frame with correct parity → commit after 24 bits; flip the parity bit of selector 2 → ERROR, `cfg_err`=1.

Source files
------------

// File: rtl/interconnect_config_loader.sv
// interconnect_config_loader
// Bit-serial loader for the interconnect selector codes. Shifts in NUM_SEL
// 5-bit codes MSB first, range-checks the whole frame, then commits it to
// interconnect_switch_bus on the same edge that releases prgm_b/CLB_prgm_b.
// Optional feature macro: CFG_PARITY_EN (adds one even-parity bit per code).
module interconnect_config_loader #(
   parameter int NUM_SEL = 4,
   parameter int SEL_W   = 5
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic                     cfg_bit,
   input  logic                     cfg_valid,
   output logic                     cfg_ready,
   output logic [NUM_SEL*SEL_W-1:0] interconnect_switch_bus,
   output logic                     prgm_b,
   output logic                     CLB_prgm_b,
   output logic                     cfg_done,
   output logic                     cfg_err
);

   localparam int SC_W = (NUM_SEL > 1) ? $clog2(NUM_SEL) : 1;
   localparam int BC_W = $clog2(SEL_W);
   localparam logic [SC_W-1:0]  LAST_SEL = SC_W'(NUM_SEL - 1);
   localparam logic [BC_W-1:0]  LAST_BIT = BC_W'(SEL_W - 1);
   localparam logic [SEL_W-1:0] MAX_CODE = SEL_W'(23);  // 5'b10111, highest routable input
   localparam logic [SEL_W-1:0] UNUSED   = '1;          // 5'b11111, "input unused"

`ifdef CFG_PARITY_EN
   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_SHIFT = 3'd1,
      S_PAR   = 3'd2,
      S_CHECK = 3'd3,
      S_DONE  = 3'd4,
      S_ERROR = 3'd5
   } state_t;
`else
   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_SHIFT = 3'd1,
      S_CHECK = 3'd3,
      S_DONE  = 3'd4,
      S_ERROR = 3'd5
   } state_t;
`endif

   state_t            state;
   logic [BC_W-1:0]   bit_cnt;
   logic [SC_W-1:0]   sel_cnt;
   logic              frame_end;   // last bit of the frame taken, shadow settles this cycle
   logic              par_err;
   logic [SEL_W-1:0]  shreg;
   logic [SEL_W-1:0]  shadow [NUM_SEL];
   logic              accept;
   logic              frame_ok;

   // Reserved codes 11000..11110 are the only illegal values.
   function automatic logic code_ok(input logic [SEL_W-1:0] code);
      return (code <= MAX_CODE) || (code == UNUSED);
   endfunction

   // Even parity: the code bits plus the parity bit XOR to zero.
   function automatic logic parity_ok(input logic [SEL_W-1:0] code, input logic pbit);
      return (^code) == pbit;
   endfunction

   assign accept = cfg_valid && cfg_ready;

   // Whole-frame range check over the shadow codes
   always_comb begin
      frame_ok = 1'b1;
      for (int i = 0; i < NUM_SEL; i++) begin
         if (!code_ok(shadow[i])) frame_ok = 1'b0;
      end
   end

   // Shift register and shadow capture; data only, no reset needed since every
   // shadow entry is rewritten before a frame is checked
   always_ff @(posedge clk) begin
      if (accept && (state == S_SHIFT)) begin
         shreg <= {shreg[SEL_W-2:0], cfg_bit};
         if (bit_cnt == LAST_BIT) shadow[sel_cnt] <= {shreg[SEL_W-2:0], cfg_bit};
      end
   end

   // Load sequencer with registered handshake, status and committed bus
   always_ff @(posedge clk) begin
      if (rst) begin
         state                   <= S_IDLE;
         bit_cnt                 <= '0;
         sel_cnt                 <= '0;
         frame_end               <= 1'b0;
         par_err                 <= 1'b0;
         interconnect_switch_bus <= '1;
         prgm_b                  <= 1'b0;
         CLB_prgm_b              <= 1'b1;
         cfg_ready               <= 1'b0;
         cfg_done                <= 1'b0;
         cfg_err                 <= 1'b0;
      end else begin
         cfg_done <= 1'b0;
         case (state)
            S_IDLE, S_DONE, S_ERROR: begin
               if (start) begin
                  state      <= S_SHIFT;
                  cfg_ready  <= 1'b1;
                  cfg_err    <= 1'b0;
                  prgm_b     <= 1'b0;
                  CLB_prgm_b <= 1'b1;
                  bit_cnt    <= '0;
                  sel_cnt    <= '0;
                  frame_end  <= 1'b0;
                  par_err    <= 1'b0;
               end
            end
            S_SHIFT: begin
               if (frame_end) begin
                  frame_end <= 1'b0;
                  state     <= S_CHECK;
               end else if (accept) begin
                  if (bit_cnt == LAST_BIT) begin
                     bit_cnt <= '0;
`ifdef CFG_PARITY_EN
                     state <= S_PAR;
`else
                     if (sel_cnt == LAST_SEL) begin
                        cfg_ready <= 1'b0;
                        frame_end <= 1'b1;
                     end else begin
                        sel_cnt <= sel_cnt + SC_W'(1);
                     end
`endif
                  end else begin
                     bit_cnt <= bit_cnt + BC_W'(1);
                  end
               end
            end
`ifdef CFG_PARITY_EN
            S_PAR: begin
               if (frame_end) begin
                  frame_end <= 1'b0;
                  state     <= S_CHECK;
               end else if (accept) begin
                  if (!parity_ok(shreg, cfg_bit)) par_err <= 1'b1;
                  if (sel_cnt == LAST_SEL) begin
                     cfg_ready <= 1'b0;
                     frame_end <= 1'b1;
                  end else begin
                     sel_cnt <= sel_cnt + SC_W'(1);
                     state   <= S_SHIFT;
                  end
               end
            end
`endif
            S_CHECK: begin
               if (frame_ok && !par_err) begin
                  for (int i = 0; i < NUM_SEL; i++) begin
                     interconnect_switch_bus[i*SEL_W +: SEL_W] <= shadow[i];
                  end
                  cfg_done   <= 1'b1;
                  prgm_b     <= 1'b1;
                  CLB_prgm_b <= 1'b0;
                  state      <= S_DONE;
               end else begin
                  cfg_err    <= 1'b1;
                  prgm_b     <= 1'b0;
                  CLB_prgm_b <= 1'b1;
                  state      <= S_ERROR;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
